// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared constants, lane-array type and controller state encoding
//             for the burst memory controller.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int NUM_RAMS = 16;  // byte lanes (memory banks) per beat
  localparam int D_WID    = 8;   // bits per lane
  localparam int CNT_W    = 5;   // width of a chunk byte count (1..16)
  localparam int RD_DEPTH = 4;   // read-return buffer depth

  typedef logic [NUM_RAMS-1:0][D_WID-1:0] lanes_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bytes moved by the next chunk: a full beat, or whatever is left.
  function automatic logic [CNT_W-1:0] chunk_bytes(input logic [31:0] remaining,
                                                   input int          lanes);
    if (remaining >= 32'(lanes)) return CNT_W'(lanes);
    return CNT_W'(remaining);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_ctrl_if
//  Purpose  : Command, write-beat, read-beat and memory-side signals of the
//             burst controller. The controller uses the slave view; the
//             requester/memory side uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_burst_ctrl_if #(
  parameter int NUM_RAMS = mem_pkg::NUM_RAMS,
  parameter int D_WID    = mem_pkg::D_WID,
  parameter int LEN_WID  = 16
);
  import mem_pkg::*;

  // command channel
  logic                               cmd_valid;
  logic                               cmd_ready;
  logic                               cmd_rdwr;
  logic [31:0]                        cmd_addr;
  logic [LEN_WID-1:0]                 cmd_len;
  // write beats
  logic                               wr_valid;
  logic                               wr_ready;
  logic [NUM_RAMS-1:0][D_WID-1:0]     wr_data;
  // read beats
  logic                               rd_valid;
  logic                               rd_ready;
  logic [NUM_RAMS-1:0][D_WID-1:0]     rd_data;
  logic [CNT_W-1:0]                   rd_bytes;
  // status
  logic                               busy;
  logic                               done;
  // memory side
  logic                               interface_en;
  logic                               interface_rdwr;
  logic [31:0]                        interface_addr;
  logic [CNT_W-1:0]                   interface_control;
  logic [NUM_RAMS-1:0][D_WID-1:0]     din;
  logic [NUM_RAMS-1:0][D_WID-1:0]     bank_dout;

  modport slave (
    input  cmd_valid, cmd_rdwr, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  bank_dout,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data, rd_bytes,
    output busy, done,
    output interface_en, interface_rdwr, interface_addr, interface_control, din
  );

  modport master (
    output cmd_valid, cmd_rdwr, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output bank_dout,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data, rd_bytes,
    input  busy, done,
    input  interface_en, interface_rdwr, interface_addr, interface_control, din
  );

endinterface
`default_nettype wire

// File: rtl/mem_burst_ctrl_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rd_fifo
//  Purpose  : Small synchronous FIFO holding returned read beats together
//             with their valid-byte count. Head entry is presented
//             combinationally; push and pop may happen in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module rd_fifo import mem_pkg::*; #(
  parameter int DEPTH = RD_DEPTH,
  parameter int WIDTH = NUM_RAMS * D_WID + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop && !w_empty;
  // a full buffer still accepts a beat when the head leaves in the same cycle
  assign w_do_push = push && (!w_full || w_do_pop);

  assign pop_data  = r_mem[r_rd_ptr];
  assign valid     = !w_empty;

  // pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // entry storage, cleared so stale beats never reappear after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_ctrl
//  Purpose  : Splits a byte-length burst command into chunks of up to one
//             beat, drives registered memory requests, and returns read beats
//             through a 4-entry buffer with bounded outstanding requests.
//  Revision : 1.0  initial release
// ============================================================================
module mem_burst_ctrl #(
  parameter int NUM_RAMS = mem_pkg::NUM_RAMS,
  parameter int D_WID    = mem_pkg::D_WID,
  parameter int LEN_WID  = 16
) (
  input  logic            clk,
  input  logic            rst,
  mem_burst_ctrl_if.slave bus
);
  import mem_pkg::*;

  localparam int LANE_BITS = NUM_RAMS * D_WID;
  localparam int ENTRY_W   = LANE_BITS + CNT_W;
  localparam int OUT_W     = $clog2(RD_DEPTH + 1);

  localparam logic [2:0] c_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] c_WRITE = 3'(ST_WRITE);
  localparam logic [2:0] c_READ  = 3'(ST_READ);
  localparam logic [2:0] c_DRAIN = 3'(ST_DRAIN);
  localparam logic [2:0] c_DONE  = 3'(ST_DONE);

  localparam logic [OUT_W-1:0] c_MAX_OUT = OUT_W'(RD_DEPTH);

  // control state
  logic [2:0]                     r_state;
  logic [31:0]                    r_addr;
  logic [LEN_WID-1:0]             r_remaining;
  logic [OUT_W-1:0]               r_outstanding;
  logic                           r_done;

  // registered memory request
  logic                           r_if_en;
  logic                           r_if_rdwr;
  logic [31:0]                    r_if_addr;
  logic [CNT_W-1:0]               r_if_ctrl;
  logic [NUM_RAMS-1:0][D_WID-1:0] r_din;

  // read return stage aligned with bank_dout
  logic                           r_p2_valid;
  logic [CNT_W-1:0]               r_p2_chunk;

  logic [CNT_W-1:0]               w_chunk;
  logic                           w_last;
  logic                           w_cmd_fire;
  logic                           w_wr_fire;
  logic                           w_rd_issue;
  logic                           w_issue;
  logic                           w_pop;
  logic                           w_fifo_valid;
  logic [NUM_RAMS-1:0][D_WID-1:0] w_rd_lanes;
  logic [ENTRY_W-1:0]             w_push_data;
  logic [ENTRY_W-1:0]             w_pop_data;

  assign w_chunk    = chunk_bytes(32'(r_remaining), NUM_RAMS);
  assign w_last     = (r_remaining == LEN_WID'(w_chunk));
  assign w_cmd_fire = bus.cmd_valid && (r_state == c_IDLE);
  assign w_wr_fire  = (r_state == c_WRITE) && bus.wr_valid;
  // outstanding counts buffered beats plus reads still in the memory pipe,
  // so capping it at the buffer depth makes overflow impossible
  assign w_rd_issue = (r_state == c_READ) && (r_outstanding < c_MAX_OUT);
  assign w_issue    = w_wr_fire || w_rd_issue;
  assign w_pop      = w_fifo_valid && bus.rd_ready;

  // lanes past the chunk carry neighbouring memory bytes; zero them
  for (genvar i = 0; i < NUM_RAMS; i++) begin : g_lane
    assign w_rd_lanes[i] = (CNT_W'(i) < r_p2_chunk) ? bus.bank_dout[i] : '0;
  end

  assign w_push_data = {w_rd_lanes, r_p2_chunk};

  rd_fifo #(
    .DEPTH (RD_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_p2_valid),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .valid     (w_fifo_valid)
  );

  assign bus.cmd_ready         = (r_state == c_IDLE);
  assign bus.wr_ready          = (r_state == c_WRITE);
  assign bus.busy              = (r_state != c_IDLE);
  assign bus.done              = r_done;
  assign bus.rd_valid          = w_fifo_valid;
  assign bus.rd_data           = w_pop_data[ENTRY_W-1:CNT_W];
  assign bus.rd_bytes          = w_pop_data[CNT_W-1:0];
  assign bus.interface_en      = r_if_en;
  assign bus.interface_rdwr    = r_if_rdwr;
  assign bus.interface_addr    = r_if_addr;
  assign bus.interface_control = r_if_ctrl;
  assign bus.din               = r_din;

  // burst sequencing: command capture, chunk advance and state transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_cmd_fire) begin
            r_addr      <= bus.cmd_addr;
            r_remaining <= bus.cmd_len;
            if (bus.cmd_len == '0)  r_state <= c_DONE;
            else if (bus.cmd_rdwr)  r_state <= c_WRITE;
            else                    r_state <= c_READ;
          end
        end
        c_WRITE: begin
          if (w_wr_fire) begin
            r_addr      <= r_addr + 32'(w_chunk);
            r_remaining <= r_remaining - LEN_WID'(w_chunk);
            if (w_last) r_state <= c_DONE;
          end
        end
        c_READ: begin
          if (w_rd_issue) begin
            r_addr      <= r_addr + 32'(w_chunk);
            r_remaining <= r_remaining - LEN_WID'(w_chunk);
            if (w_last) r_state <= c_DRAIN;
          end
        end
        c_DRAIN: begin
          if (r_outstanding == '0) r_state <= c_DONE;
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // read credit: one per issued read, returned when its beat is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_issue, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // registered memory request; en drops in any cycle without a chunk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_en   <= 1'b0;
      r_if_rdwr <= 1'b0;
      r_if_addr <= '0;
      r_if_ctrl <= '0;
      r_din     <= '0;
    end else begin
      r_if_en <= w_issue;
      if (w_issue) begin
        r_if_rdwr <= w_wr_fire;
        r_if_addr <= r_addr;
        r_if_ctrl <= w_chunk;
      end
      if (w_wr_fire) r_din <= bus.wr_data;
    end
  end

  // read return alignment and the completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p2_valid <= 1'b0;
      r_p2_chunk <= '0;
      r_done     <= 1'b0;
    end else begin
      r_p2_valid <= r_if_en && !r_if_rdwr;
      r_p2_chunk <= r_if_ctrl;
      r_done     <= (r_state == c_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_burst_ctrl
//  Purpose  : Directed self-checking bench for mem_burst_ctrl with a 256-byte
//             behavioural memory behind the request interface.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_burst_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_burst_ctrl_if #(.NUM_RAMS(16), .D_WID(8), .LEN_WID(16)) bus ();

  mem_burst_ctrl #(.NUM_RAMS(16), .D_WID(8), .LEN_WID(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // behavioural memory: writes take effect at the request edge, read lanes
  // appear the cycle after interface_en
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a) ^ 8'h5A;
      bus.bank_dout <= '0;
    end else if (bus.interface_en) begin
      if (bus.interface_rdwr) begin
        for (int i = 0; i < 16; i++)
          if (i < int'(bus.interface_control))
            mem[bus.interface_addr[7:0] + 8'(i)] <= bus.din[i];
      end else begin
        for (int i = 0; i < 16; i++)
          bus.bank_dout[i] <= mem[bus.interface_addr[7:0] + 8'(i)];
      end
    end
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory contents expected after the 40-byte write at 0x3
  function automatic logic [7:0] gold(input int a);
    int k;
    k = a & 255;
    if (k >= 3 && k < 43) return 8'(8'h40 + (k - 3));
    return 8'(k) ^ 8'h5A;
  endfunction

  function automatic logic [127:0] gold_beat(input int a, input int n);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) if (i < n) b[i*8 +: 8] = gold(a + i);
    return b;
  endfunction

  task automatic start_cmd(input logic rdwr, input logic [31:0] addr, input logic [15:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_rdwr  = rdwr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // drain read beats with rd_ready held high until done, checking each beat
  task automatic collect_read(input string tag, input int addr, input int len);
    int  beats;
    int  offs;
    int  n;
    bit  seen_done;
    beats     = 0;
    offs      = 0;
    seen_done = 1'b0;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (bus.done) begin
        seen_done = 1'b1;
      end else begin
        if (bus.rd_valid) begin
          n = (len - offs > 16) ? 16 : len - offs;
          check_eq({tag, "_bytes"}, 128'(bus.rd_bytes), 128'(n));
          check_eq({tag, "_data"}, 128'(bus.rd_data), gold_beat(addr + offs, n));
          offs  += n;
          beats++;
        end
        tick();
      end
    end
    check_eq({tag, "_beats"}, 128'(beats), 128'((len + 15) / 16));
    check_eq({tag, "_done"}, 128'(seen_done), 128'(1));
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    lanes_t beat;
    int     n_en;
    int     bad;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rdwr  = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // reset state
    repeat (3) tick();
    check_eq("rst_flags", 128'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy,
                                bus.done, bus.interface_en, bus.interface_rdwr}), 128'(7'b1000000));
    check_eq("rst_addr", 128'(bus.interface_addr), 128'(0));
    check_eq("rst_ctrl", 128'(bus.interface_control), 128'(0));
    check_eq("rst_din", 128'(bus.din), 128'(0));
    rst = 1'b0;
    tick();

    // 40-byte write from an unaligned address: chunks 16,16,8
    start_cmd(1'b1, 32'h3, 16'd40);
    check_eq("wr_accept", 128'({bus.cmd_ready, bus.wr_ready, bus.busy}), 128'(3'b011));
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) beat[i] = 8'(8'h40 + 16 * b + i);
      bus.wr_valid = 1'b1;
      bus.wr_data  = beat;
      tick();
      check_eq($sformatf("wr_flags%0d", b), 128'({bus.interface_en, bus.interface_rdwr, bus.done}), 128'(3'b110));
      check_eq($sformatf("wr_addr%0d", b), 128'(bus.interface_addr), 128'(3 + 16 * b));
      check_eq($sformatf("wr_ctrl%0d", b), 128'(bus.interface_control), 128'((b == 2) ? 8 : 16));
      check_eq($sformatf("wr_din%0d", b), 128'(bus.din), 128'(beat));
    end
    bus.wr_valid = 1'b0;
    tick();
    check_eq("wr_done", 128'({bus.interface_en, bus.done}), 128'(2'b01));
    tick();
    check_eq("wr_after", 128'({bus.done, bus.cmd_ready, bus.busy}), 128'(3'b010));

    // single aligned beat read back from the written region
    start_cmd(1'b0, 32'h10, 16'd16);
    collect_read("rd16", 16, 16);

    // long read with back-pressure: credit limit of four chunks
    start_cmd(1'b0, 32'h0, 16'd100);
    n_en = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.interface_en) n_en++;
      tick();
    end
    check_eq("rd100_issued", 128'(n_en), 128'(4));
    check_eq("rd100_stall", 128'({bus.interface_en, bus.rd_valid, bus.busy}), 128'(3'b011));
    collect_read("rd100", 0, 100);

    // zero-length command: no memory traffic, done two cycles after accept
    check_eq("len0_ready", 128'(bus.cmd_ready), 128'(1));
    start_cmd(1'b0, 32'h20, 16'd0);
    check_eq("len0_c1", 128'({bus.interface_en, bus.done, bus.busy}), 128'(3'b001));
    tick();
    check_eq("len0_c2", 128'({bus.interface_en, bus.done}), 128'(2'b01));
    tick();
    check_eq("len0_c3", 128'({bus.interface_en, bus.done, bus.cmd_ready}), 128'(3'b001));

    // reset with two beats buffered
    start_cmd(1'b0, 32'h0, 16'd100);
    repeat (4) tick();
    check_eq("pre_rst_valid", 128'(bus.rd_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async", 128'({bus.rd_valid, bus.cmd_ready, bus.busy, bus.interface_en, bus.done}),
             128'(5'b01000));
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.done || bus.rd_valid || bus.interface_en) bad++;
      tick();
    end
    check_eq("post_rst_quiet", 128'(bad), 128'(0));
    check_eq("post_rst_ready", 128'(bus.cmd_ready), 128'(1));
    start_cmd(1'b1, 32'h80, 16'd4);
    check_eq("post_rst_accept", 128'({bus.busy, bus.wr_ready}), 128'(2'b11));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
